// File: rtl/knob_quantizer.sv
// knob_quantizer: turns raw potentiometer readings into discrete control levels.
// A sample strobe snapshots all channels. The channels are then scanned one per
// clock. Each channel's level only moves once its candidate has cleared the
// hysteresis margin and has stayed the same for STABLE_SAMPLES strobes in a row.
//
// Ports:
//   clk            board clock
//   reset          synchronous, active-high
//   user_input     NCH x IN_W raw values, channel i at [i*IN_W +: IN_W]
//   sample_valid   one-cycle strobe: new values on all channels
//   level          NCH x OUT_W committed levels, channel i at [i*OUT_W +: OUT_W]
//   level_changed  one-cycle pulse per channel when its level commits
//   busy           scan in progress
//   overrun        one-cycle pulse after a strobe that arrived while busy
module knob_quantizer #(
  parameter int NCH            = 4,
  parameter int IN_W           = 10,
  parameter int LEVELS         = 5,
  parameter int OUT_W          = 4,
  parameter int HYST           = 8,
  parameter int STABLE_SAMPLES = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NCH*IN_W-1:0]   user_input,
  input  logic                  sample_valid,
  output logic [NCH*OUT_W-1:0]  level,
  output logic [NCH-1:0]        level_changed,
  output logic                  busy,
  output logic                  overrun
);

  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW   = IN_W + OUT_W + 1;
  localparam logic [IN_W:0]    XMAX   = (IN_W+1)'((1 << IN_W) - 1);
  localparam logic [IN_W:0]    HYST_W = (IN_W+1)'(HYST);
  localparam logic [PW-1:0]    LV     = PW'(LEVELS);
  localparam logic [OUT_W:0]   LMAX   = (OUT_W+1)'(LEVELS - 1);
  localparam logic [CH_W-1:0]  LAST   = CH_W'(NCH - 1);
  localparam logic [8:0]       SS     = 9'(STABLE_SAMPLES);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                      state;
  logic [CH_W-1:0]             ch;
  logic [NCH-1:0][IN_W-1:0]    snap;
  logic [NCH-1:0][OUT_W-1:0]   cur, pend;
  logic [NCH-1:0][7:0]         cnt;

  assign level = cur;

  // Shared evaluator for the channel currently under scan.
  logic [IN_W-1:0]  x;
  logic [IN_W:0]    x_lo, x_hi;
  logic [PW-1:0]    p_up, p_dn;
  logic [OUT_W:0]   q_up, q_dn;
  logic [OUT_W-1:0] up, dn, tgt, cur_c, pend_c, nxt_cur, nxt_pend;
  logic [7:0]       cnt_c, nxt_cnt;
  logic             commit;

  always_comb begin
    x      = snap[ch];
    cur_c  = cur[ch];
    pend_c = pend[ch];
    cnt_c  = cnt[ch];

    // Saturating offsets keep the thresholds inside the ADC range.
    x_lo = ({1'b0, x} >= HYST_W) ? ({1'b0, x} - HYST_W) : '0;
    x_hi = {1'b0, x} + HYST_W;
    if (x_hi > XMAX) x_hi = XMAX;

    p_up = PW'(x_lo) * LV;
    p_dn = PW'(x_hi) * LV;
    q_up = p_up[PW-1:IN_W];
    q_dn = p_dn[PW-1:IN_W];
    up   = (q_up > LMAX) ? LMAX[OUT_W-1:0] : q_up[OUT_W-1:0];
    dn   = (q_dn > LMAX) ? LMAX[OUT_W-1:0] : q_dn[OUT_W-1:0];

    // Going up needs the reading to exceed a boundary by HYST.
    // Going down needs it to fall below a boundary by HYST.
    if (up > cur_c)      tgt = up;
    else if (dn < cur_c) tgt = dn;
    else                 tgt = cur_c;

    nxt_cur  = cur_c;
    nxt_pend = pend_c;
    nxt_cnt  = cnt_c;
    commit   = 1'b0;
    if (tgt == cur_c) begin
      nxt_cnt = '0;
    end else if (tgt == pend_c) begin
      if ({1'b0, cnt_c} + 9'd1 == SS) begin
        nxt_cur = tgt;
        nxt_cnt = '0;
        commit  = 1'b1;
      end else begin
        nxt_cnt = cnt_c + 8'd1;
      end
    end else begin
      nxt_pend = tgt;
      if (STABLE_SAMPLES == 1) begin
        nxt_cur = tgt;
        nxt_cnt = '0;
        commit  = 1'b1;
      end else begin
        nxt_cnt = 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      ch            <= '0;
      snap          <= '0;
      cur           <= '0;
      pend          <= '0;
      cnt           <= '0;
      level_changed <= '0;
      busy          <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      level_changed <= '0;
      // A strobe during a scan is dropped. It only raises overrun.
      overrun       <= sample_valid & busy;
      case (state)
        IDLE: begin
          if (sample_valid) begin
            snap  <= user_input;
            ch    <= '0;
            busy  <= 1'b1;
            state <= SCAN;
          end
        end
        SCAN: begin
          cur[ch]           <= nxt_cur;
          pend[ch]          <= nxt_pend;
          cnt[ch]           <= nxt_cnt;
          level_changed[ch] <= commit;
          if (ch == LAST) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            ch <= ch + CH_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_knob_quantizer.sv
// Scoreboard bench for knob_quantizer. Each accepted strobe runs a reference
// model and queues one expected (level, level_changed) snapshot per channel.
// Those snapshots are popped in the cycles where each channel's result appears.
module tb_knob_quantizer;
  localparam int NCH = 4, IN_W = 10, LEVELS = 5, OUT_W = 4, HYST = 8, SS = 3;
  localparam int XMAXI = (1 << IN_W) - 1;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NCH*IN_W-1:0]  user_input = '0;
  logic                 sample_valid = 1'b0;
  logic [NCH*OUT_W-1:0] level;
  logic [NCH-1:0]       level_changed;
  logic                 busy, overrun;

  knob_quantizer #(
    .NCH(NCH), .IN_W(IN_W), .LEVELS(LEVELS), .OUT_W(OUT_W),
    .HYST(HYST), .STABLE_SAMPLES(SS)
  ) dut (
    .clk(clk), .reset(reset), .user_input(user_input),
    .sample_valid(sample_valid), .level(level),
    .level_changed(level_changed), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NCH*OUT_W-1:0] lvl;
    logic [NCH-1:0]       chg;
  } exp_t;

  exp_t sb[$];
  int   m_cur[NCH], m_pend[NCH], m_cnt[NCH];
  int   n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [NCH*IN_W-1:0] mk(input int a, input int b, input int c, input int d);
    return {IN_W'(d), IN_W'(c), IN_W'(b), IN_W'(a)};
  endfunction

  function automatic int quant(input int v);
    int r;
    r = (v * LEVELS) / (1 << IN_W);
    return (r > LEVELS - 1) ? LEVELS - 1 : r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_cur[i] = 0; m_pend[i] = 0; m_cnt[i] = 0;
    end
    sb.delete();
  endtask

  // Reference model: walk the channels in scan order, one expectation each.
  task automatic push_exp(input logic [NCH*IN_W-1:0] v);
    exp_t e;
    int x, lo, hi, up, dn, tgt;
    bit cm;
    for (int i = 0; i < NCH; i++) begin
      x  = int'(v[i*IN_W +: IN_W]);
      lo = x - HYST; if (lo < 0) lo = 0;
      hi = x + HYST; if (hi > XMAXI) hi = XMAXI;
      up = quant(lo);
      dn = quant(hi);
      tgt = (up > m_cur[i]) ? up : (dn < m_cur[i]) ? dn : m_cur[i];
      cm = 1'b0;
      if (tgt == m_cur[i]) m_cnt[i] = 0;
      else if (tgt == m_pend[i]) begin
        if (m_cnt[i] + 1 == SS) begin m_cur[i] = tgt; m_cnt[i] = 0; cm = 1'b1; end
        else m_cnt[i]++;
      end else begin
        m_pend[i] = tgt;
        if (SS == 1) begin m_cur[i] = tgt; m_cnt[i] = 0; cm = 1'b1; end
        else m_cnt[i] = 1;
      end
      for (int j = 0; j < NCH; j++) e.lvl[j*OUT_W +: OUT_W] = OUT_W'(m_cur[j]);
      e.chg = cm ? NCH'(1 << i) : '0;
      sb.push_back(e);
    end
  endtask

  // Strobe at cycle T, then check cycles T+1..T+NCH+1. If rej_at > 0, a second
  // strobe carrying garbage is raised in cycle T+rej_at and must be ignored.
  task automatic run_sample(input logic [NCH*IN_W-1:0] v, input int rej_at);
    exp_t e;
    @(posedge clk); #1;
    user_input = v; sample_valid = 1'b1;
    push_exp(v);
    for (int k = 1; k <= NCH + 1; k++) begin
      @(posedge clk); #1;
      sample_valid = (k == rej_at);
      user_input = (NCH*IN_W)'({$urandom(), $urandom()});
      @(negedge clk);
      chk($sformatf("busy T+%0d", k), 32'(busy), 32'(k <= NCH));
      chk($sformatf("overrun T+%0d", k), 32'(overrun), 32'(rej_at > 0 && k == rej_at + 1));
      if (k == 1) chk("changed T+1", 32'(level_changed), 32'd0);
      else begin
        chk("sb_size", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk($sformatf("level ch%0d", k - 2), 32'(level), 32'(e.lvl));
          chk($sformatf("changed ch%0d", k - 2), 32'(level_changed), 32'(e.chg));
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int base[NCH];
    int xv[NCH];
    model_reset();
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst level", 32'(level), 32'd0);
    chk("rst changed", 32'(level_changed), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst overrun", 32'(overrun), 32'd0);
    @(posedge clk); #1; reset = 1'b0;

    // ch0 full scale: level 4 commits on the third strobe
    repeat (3) run_sample(mk(1023, 0, 0, 0), 0);
    chk("ch0 level4", 32'(level[0 +: OUT_W]), 32'd4);

    // ch1 hysteresis up and down around the 1/2 boundary (409.6)
    repeat (3) run_sample(mk(1023, 300, 0, 0), 0);
    repeat (3) run_sample(mk(1023, 412, 0, 0), 0);
    chk("ch1 hold 412", 32'(level[OUT_W +: OUT_W]), 32'd1);
    repeat (3) run_sample(mk(1023, 418, 0, 0), 0);
    chk("ch1 up 418", 32'(level[OUT_W +: OUT_W]), 32'd2);
    repeat (3) run_sample(mk(1023, 405, 0, 0), 0);
    chk("ch1 hold 405", 32'(level[OUT_W +: OUT_W]), 32'd2);
    repeat (3) run_sample(mk(1023, 400, 0, 0), 0);
    chk("ch1 down 400", 32'(level[OUT_W +: OUT_W]), 32'd1);

    // ch2 interrupted run must restart the stability count
    run_sample(mk(1023, 400, 1023, 0), 0);
    run_sample(mk(1023, 400, 1023, 0), 0);
    run_sample(mk(1023, 400, 300, 0), 0);
    run_sample(mk(1023, 400, 1023, 0), 0);
    run_sample(mk(1023, 400, 1023, 0), 0);
    chk("ch2 no early commit", 32'(level[2*OUT_W +: OUT_W]), 32'd0);
    run_sample(mk(1023, 400, 1023, 0), 0);
    chk("ch2 commit", 32'(level[2*OUT_W +: OUT_W]), 32'd4);

    // Strobe at T+2 is rejected; the first scan is unaffected
    run_sample(mk(1023, 400, 1023, 1023), 2);

    // ch1 has a commit pending for the third strobe; reset in T+2 kills it
    run_sample(mk(1023, 1023, 1023, 1023), 0);
    run_sample(mk(1023, 1023, 1023, 1023), 0);
    @(posedge clk); #1; user_input = mk(1023, 1023, 1023, 1023); sample_valid = 1'b1;
    @(posedge clk); #1; sample_valid = 1'b0;
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("midrst level", 32'(level), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst changed", 32'(level_changed), 32'd0);
    @(negedge clk);
    chk("postrst changed", 32'(level_changed), 32'd0);
    chk("postrst busy", 32'(busy), 32'd0);
    model_reset();
    // Pending counts were discarded: a single strobe must not commit
    run_sample(mk(1023, 1023, 1023, 1023), 0);

    // Jittery readings around random set points
    for (int s = 0; s < 12; s++) begin
      if (s % 4 == 0)
        for (int c = 0; c < NCH; c++) base[c] = int'($urandom_range(0, XMAXI));
      for (int c = 0; c < NCH; c++) begin
        xv[c] = base[c] + int'($urandom_range(0, 24)) - 12;
        if (xv[c] < 0) xv[c] = 0;
        if (xv[c] > XMAXI) xv[c] = XMAXI;
      end
      run_sample(mk(xv[0], xv[1], xv[2], xv[3]), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
